// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-serial memory controller arbitrating instruction fetch and load/store
// onto one byte-wide synchronous RAM port.
module mem_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_data,
    output logic        if_done,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [1:0]  mem_width,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_done,
    input  logic        jump_flag,
    output logic        busy_line,
    output logic [31:0] ram_a,
    output logic [7:0]  ram_dout,
    output logic        ram_wr,
    input  logic [7:0]  ram_din
);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t      state_q, state_d;
    logic        is_mem_q, is_mem_d;
    logic [31:0] base_q, base_d;
    logic [2:0]  n_q, n_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] asm_q, asm_d;
    logic [31:0] if_data_q, if_data_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;
    logic [31:0] byte_addr;

    // Wraps naturally at 2^32 because the sum is truncated to 32 bits.
    assign byte_addr = base_q + {29'd0, cnt_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            is_mem_q    <= 1'b0;
            base_q      <= 32'd0;
            n_q         <= 3'd0;
            wdata_q     <= 32'd0;
            cnt_q       <= 3'd0;
            asm_q       <= 32'd0;
            if_data_q   <= 32'd0;
            mem_rdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            is_mem_q    <= is_mem_d;
            base_q      <= base_d;
            n_q         <= n_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            asm_q       <= asm_d;
            if_data_q   <= if_data_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        is_mem_d    = is_mem_q;
        base_d      = base_q;
        n_d         = n_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        asm_d       = asm_q;
        if_data_d   = if_data_q;
        mem_rdata_d = mem_rdata_q;
        ram_a       = 32'd0;
        ram_dout    = 8'd0;
        ram_wr      = 1'b0;

        case (state_q)
            IDLE: begin
                if (mem_req) begin
                    is_mem_d = 1'b1;
                    base_d   = mem_addr;
                    wdata_d  = mem_wdata;
                    cnt_d    = 3'd0;
                    asm_d    = 32'd0;
                    case (mem_width)
                        2'd0:    n_d = 3'd1;
                        2'd1:    n_d = 3'd2;
                        default: n_d = 3'd4;
                    endcase
                    state_d = mem_we ? WR : RD;
                end else if (if_req && !jump_flag) begin
                    is_mem_d = 1'b0;
                    base_d   = if_addr;
                    n_d      = 3'd4;
                    cnt_d    = 3'd0;
                    asm_d    = 32'd0;
                    state_d  = RD;
                end
            end
            RD: begin
                if (cnt_q < n_q) begin
                    ram_a = byte_addr;
                end
                if (!is_mem_q && jump_flag) begin
                    state_d = IDLE;
                    cnt_d   = 3'd0;
                end else begin
                    // RAM data lags the address by one cycle, so byte cnt-1 arrives now.
                    case (cnt_q)
                        3'd1:    asm_d[7:0]   = ram_din;
                        3'd2:    asm_d[15:8]  = ram_din;
                        3'd3:    asm_d[23:16] = ram_din;
                        3'd4:    asm_d[31:24] = ram_din;
                        default: ;
                    endcase
                    if (cnt_q == n_q) begin
                        state_d = DONE;
                        cnt_d   = 3'd0;
                        if (is_mem_q) begin
                            mem_rdata_d = asm_d;
                        end else begin
                            if_data_d = asm_d;
                        end
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            WR: begin
                ram_a  = byte_addr;
                ram_wr = 1'b1;
                case (cnt_q)
                    3'd0:    ram_dout = wdata_q[7:0];
                    3'd1:    ram_dout = wdata_q[15:8];
                    3'd2:    ram_dout = wdata_q[23:16];
                    default: ram_dout = wdata_q[31:24];
                endcase
                if (cnt_q == n_q - 3'd1) begin
                    state_d = DONE;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = 3'd0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 3'd0;
            end
        endcase
    end

    // A flush landing on the fetch's DONE cycle swallows the completion pulse.
    assign if_done   = (state_q == DONE) && !is_mem_q && !jump_flag;
    assign mem_done  = (state_q == DONE) && is_mem_q;
    assign if_data   = if_data_q;
    assign mem_rdata = mem_rdata_q;
    assign busy_line = (if_req || mem_req) && !(if_done || mem_done);

endmodule
